ctl_reg_reader: RTL and testbench
=================================

CTL_REG_READER -- requirements
Module: ctl_reg_reader

Interface
REQ-001 Parameter RD_LATENCY, default 2: controller BRAM read latency in cycles, from address presented to data valid.
REQ-002 CLK  in  1  system clock; all logic on the rising edge.
REQ-003 RST  in  1  reset, synchronous and active-high.
REQ-004 BRAM_ADDR  out  8  controller BRAM address (BRAM_SELECT_CONTROLLER page).
REQ-005 BRAM_DIN  in  16  BRAM read data.
REQ-006 BRAM_DOUT  out  16  BRAM write data.
REQ-007 BRAM_WE  out  1  BRAM write enable.
REQ-008 THERMO  in  1  thermal-alarm input.
REQ-009 FORCE_FAN  out  1  latched CTL_FLAG bit 13.
REQ-010 SILENCER_MODE  out  1  0 = fixed completion steps, 1 = fixed update rate.
REQ-011 UPDATE_RATE_INTENSITY, UPDATE_RATE_PHASE, COMPLETION_STEPS_INTENSITY, COMPLETION_STEPS_PHASE  out  16 each  silencer settings.
REQ-012 SILENCER_UPDATE  out  1  one-cycle pulse when all silencer outputs are new.
REQ-013 DEBUG_TYPE[0:3]  out  8 each; DEBUG_VALUE[0:3]  out  16 each; DEBUG_UPDATE  out  1 pulse (present only under DEBUG_SETTINGS_EN).

Function
REQ-014 States: INIT_VER_MAJ, INIT_VER_MIN, RD_CTL, WAIT_CTL, DISPATCH, RD_SIL, RD_DBG, WR_STATE; encoding free.
REQ-015 INIT_VER_MAJ: write 0x0090 to 0x02. INIT_VER_MIN: write 0x0000 to 0x03. Each state takes one cycle with WE=1. Then go to RD_CTL.
REQ-016 RD_CTL: drive address 0x00 with WE=0, then wait RD_LATENCY cycles in WAIT_CTL, then capture CTL_FLAG.
REQ-017 DISPATCH: FORCE_FAN <= CTL_FLAG[13] every poll. Rising edge of bit 2 versus the previously captured flag -> RD_SIL. Else rising edge of bit 4 -> RD_DBG. Else -> WR_STATE.
REQ-018 Both edges in one poll: RD_SIL runs first, then RD_DBG, then WR_STATE. The previous-flag register is updated only after both groups are served.
REQ-019 RD_SIL: issue addresses 0x40..0x44 on consecutive cycles (pipelined). Capture data RD_LATENCY cycles after each address. SILENCER_MODE takes bit 0 of 0x40.
REQ-020 Silencer outputs update together on the cycle the last word arrives. SILENCER_UPDATE is high exactly that cycle. Intermediate words go to shadow registers.
REQ-021 RD_DBG: issue addresses 0xF0..0xF7 pipelined. DEBUG_TYPEn takes the low 8 bits of 0xF0+2n. DEBUG_VALUEn takes 0xF1+2n. Apply atomically with a one-cycle DEBUG_UPDATE pulse.
REQ-022 WR_STATE: write {15'b0, THERMO} to 0x01 with WE=1 for one cycle, then return to RD_CTL. Polling runs forever.
REQ-023 BRAM_WE is never high in any read state. BRAM_DOUT is 0 whenever WE=0.
REQ-024 A flag bit held at 1 across polls triggers no reload. Clearing the bit to 0 and setting it again re-triggers.
REQ-025 Poll period with no groups = 1 + RD_LATENCY + 1 (DISPATCH) + 1 (WR_STATE) cycles.

Reset
REQ-026 On RST=1: state goes to INIT_VER_MAJ; all outputs, shadows and the previous flag clear to 0.
REQ-027 RST asserted mid-burst discards partial shadows. No UPDATE pulse occurs, and previously applied outputs are cleared.
REQ-028 The version writes are reissued after every reset release.

Configuration
REQ-029 Macro DEBUG_SETTINGS_EN defined: RD_DBG and the debug ports exist.
REQ-030 Macro DEBUG_SETTINGS_EN undefined: debug ports and state are absent, and CTL_FLAG bit 4 is ignored. Silencer, fan and state behaviour are unchanged.

Verification
REQ-031 Release reset -> first two cycles write 0x0090@0x02 then 0x0000@0x03; next cycle reads address 0x00.
REQ-032 Preload 0x40..0x44 = 1, 0x0100, 0x0200, 10, 40; set CTL_FLAG = 0x0004 -> one SILENCER_UPDATE pulse with MODE=1, rates 0x0100/0x0200, steps 10/40; no further pulses while the flag stays 0x0004.
REQ-033 CTL_FLAG = 0x0014 with DEBUG_SETTINGS_EN, debug regs 0xF0..0xF7 = 0x01, 5, 0x02, 6, 0x10, 7, 0xE0, 8 -> SILENCER_UPDATE precedes DEBUG_UPDATE; DEBUG_TYPE = 01/02/10/E0 and DEBUG_VALUE = 5/6/7/8.
REQ-034 THERMO=1 -> each poll writes 0x0001@0x01; CTL_FLAG = 0x2000 -> FORCE_FAN=1 by the next DISPATCH.
REQ-035 RST pulsed during the 3rd RD_SIL word -> no SILENCER_UPDATE pulse, outputs 0, sequence restarts at the version writes.
REQ-036 CTL_FLAG toggled 0x0004 -> 0 -> 0x0004 -> exactly two SILENCER_UPDATE pulses.

Source files
------------

// File: rtl/ctl_reg_reader_if.sv
// ctl_reg_reader_if -- controller BRAM port bundle.
//   BRAM_ADDR  8   address driven by the controller
//   BRAM_DIN   16  read data returned by the BRAM
//   BRAM_DOUT  16  write data driven by the controller
//   BRAM_WE    1   write enable driven by the controller
// master: the register reader; slave: the BRAM side.
interface ctl_reg_reader_if;
  logic [7:0]  BRAM_ADDR;
  logic [15:0] BRAM_DIN;
  logic [15:0] BRAM_DOUT;
  logic        BRAM_WE;

  modport master (output BRAM_ADDR, output BRAM_DOUT, output BRAM_WE, input BRAM_DIN);
  modport slave  (input BRAM_ADDR, input BRAM_DOUT, input BRAM_WE, output BRAM_DIN);
endinterface

// File: rtl/ctl_reg_reader.sv
// ctl_reg_reader -- polls the controller BRAM page, publishes version words,
// reloads silencer (and optionally debug) settings on rising CTL_FLAG bits and
// writes back the thermal status every poll.
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   bram (master)        controller BRAM port (address/data/write enable)
//   THERMO               thermal alarm, reported at address 0x01
//   FORCE_FAN            latched CTL_FLAG bit 13
//   SILENCER_MODE        bit 0 of word 0x40
//   UPDATE_RATE_*/COMPLETION_STEPS_*  words 0x41..0x44
//   SILENCER_UPDATE      one-cycle pulse when silencer outputs change
//   DEBUG_TYPE/VALUE/UPDATE  debug settings from 0xF0..0xF7
// Build option: define DEBUG_SETTINGS_EN to include the debug reload and ports.
// Read timing: data for an address presented in cycle t is sampled at the end
// of cycle t+RD_LATENCY.
module ctl_reg_reader #(
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  ctl_reg_reader_if.master     bram,
  input  logic                 THERMO,
  output logic                 FORCE_FAN,
  output logic                 SILENCER_MODE,
  output logic [15:0]          UPDATE_RATE_INTENSITY,
  output logic [15:0]          UPDATE_RATE_PHASE,
  output logic [15:0]          COMPLETION_STEPS_INTENSITY,
  output logic [15:0]          COMPLETION_STEPS_PHASE,
  output logic                 SILENCER_UPDATE
`ifdef DEBUG_SETTINGS_EN
  ,
  output logic [7:0]           DEBUG_TYPE  [0:3],
  output logic [15:0]          DEBUG_VALUE [0:3],
  output logic                 DEBUG_UPDATE
`endif
);

  localparam logic [7:0] LAT      = 8'(RD_LATENCY);
  localparam logic [7:0] LAT_M1   = 8'(RD_LATENCY - 1);
  localparam logic [7:0] SIL_LAST = 8'(RD_LATENCY + 4);
`ifdef DEBUG_SETTINGS_EN
  localparam logic [7:0] DBG_LAST = 8'(RD_LATENCY + 7);
`endif

  typedef enum logic [2:0] {
    INIT_VER_MAJ,
    INIT_VER_MIN,
    RD_CTL,
    WAIT_CTL,
    DISPATCH,
    RD_SIL,
    WR_STATE
`ifdef DEBUG_SETTINGS_EN
    ,
    RD_DBG
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cap_idx;

  // only the flag bits the poller acts on are kept
  logic        flag_sil_q, flag_fan_q, prev_sil_q;
  logic        sil_edge;

  logic        force_fan_q;
  logic        mode_q, sh_mode_q;
  logic [15:0] uri_q, urp_q, csi_q, csp_q;
  logic [15:0] sh_uri_q, sh_urp_q, sh_csi_q;
  logic        sil_upd_q;

`ifdef DEBUG_SETTINGS_EN
  logic        flag_dbg_q, prev_dbg_q;
  logic        dbg_edge;
  logic [7:0]  dbg_type_q [0:3];
  logic [15:0] dbg_val_q  [0:3];
  logic [7:0]  sh_type_q  [0:3];
  logic [15:0] sh_val_q   [0:3];
  logic        dbg_upd_q;
`endif

  // index of the word whose data is on BRAM_DIN this cycle in a burst
  assign cap_idx  = cnt_q - LAT;
  assign sil_edge = flag_sil_q & ~prev_sil_q;
`ifdef DEBUG_SETTINGS_EN
  assign dbg_edge = flag_dbg_q & ~prev_dbg_q;
`endif

  // state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= INIT_VER_MAJ;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next-state logic; cnt_q counts cycles spent in the current state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT_VER_MAJ: state_d = INIT_VER_MIN;
      INIT_VER_MIN: state_d = RD_CTL;
      RD_CTL:       state_d = WAIT_CTL;
      WAIT_CTL:     if (cnt_q == LAT_M1) state_d = DISPATCH;
      DISPATCH: begin
        if (sil_edge) state_d = RD_SIL;
`ifdef DEBUG_SETTINGS_EN
        else if (dbg_edge) state_d = RD_DBG;
`endif
        else state_d = WR_STATE;
      end
      RD_SIL: begin
        if (cnt_q == SIL_LAST) begin
          state_d = WR_STATE;
`ifdef DEBUG_SETTINGS_EN
          if (dbg_edge) state_d = RD_DBG;
`endif
        end
      end
`ifdef DEBUG_SETTINGS_EN
      RD_DBG:       if (cnt_q == DBG_LAST) state_d = WR_STATE;
`endif
      WR_STATE:     state_d = RD_CTL;
      default:      state_d = INIT_VER_MAJ;
    endcase
    cnt_d = (state_d == state_q) ? cnt_q + 8'd1 : '0;
  end

  // BRAM port outputs; held quiet while reset is asserted
  always_comb begin
    bram.BRAM_ADDR = '0;
    bram.BRAM_DOUT = '0;
    bram.BRAM_WE   = 1'b0;
    if (!RST) begin
      unique case (state_q)
        INIT_VER_MAJ: begin
          bram.BRAM_ADDR = 8'h02;
          bram.BRAM_DOUT = 16'h0090;
          bram.BRAM_WE   = 1'b1;
        end
        INIT_VER_MIN: begin
          bram.BRAM_ADDR = 8'h03;
          bram.BRAM_WE   = 1'b1;
        end
        // the issue address saturates on the last word while the tail drains
        RD_SIL:   bram.BRAM_ADDR = 8'h40 + ((cnt_q < 8'd5) ? cnt_q : 8'd4);
`ifdef DEBUG_SETTINGS_EN
        RD_DBG:   bram.BRAM_ADDR = 8'hF0 + ((cnt_q < 8'd8) ? cnt_q : 8'd7);
`endif
        WR_STATE: begin
          bram.BRAM_ADDR = 8'h01;
          bram.BRAM_DOUT = {15'b0, THERMO};
          bram.BRAM_WE   = 1'b1;
        end
        default:  bram.BRAM_ADDR = 8'h00;
      endcase
    end
  end

  // datapath: flag capture, shadow loading and atomic apply
  always_ff @(posedge CLK) begin
    if (RST) begin
      flag_sil_q  <= 1'b0;
      flag_fan_q  <= 1'b0;
      prev_sil_q  <= 1'b0;
      force_fan_q <= 1'b0;
      mode_q      <= 1'b0;
      sh_mode_q   <= 1'b0;
      uri_q       <= '0;
      urp_q       <= '0;
      csi_q       <= '0;
      csp_q       <= '0;
      sh_uri_q    <= '0;
      sh_urp_q    <= '0;
      sh_csi_q    <= '0;
      sil_upd_q   <= 1'b0;
`ifdef DEBUG_SETTINGS_EN
      flag_dbg_q  <= 1'b0;
      prev_dbg_q  <= 1'b0;
      dbg_upd_q   <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        dbg_type_q[i] <= '0;
        dbg_val_q[i]  <= '0;
        sh_type_q[i]  <= '0;
        sh_val_q[i]   <= '0;
      end
`endif
    end else begin
      sil_upd_q <= 1'b0;
`ifdef DEBUG_SETTINGS_EN
      dbg_upd_q <= 1'b0;
`endif
      if (state_q == WAIT_CTL && cnt_q == LAT_M1) begin
        flag_sil_q <= bram.BRAM_DIN[2];
        flag_fan_q <= bram.BRAM_DIN[13];
`ifdef DEBUG_SETTINGS_EN
        flag_dbg_q <= bram.BRAM_DIN[4];
`endif
      end
      if (state_q == DISPATCH) force_fan_q <= flag_fan_q;
      // edge history advances only once every triggered group has been read
      if (state_q == WR_STATE) begin
        prev_sil_q <= flag_sil_q;
`ifdef DEBUG_SETTINGS_EN
        prev_dbg_q <= flag_dbg_q;
`endif
      end
      if (state_q == RD_SIL && cnt_q >= LAT) begin
        case (cap_idx)
          8'd0: sh_mode_q <= bram.BRAM_DIN[0];
          8'd1: sh_uri_q  <= bram.BRAM_DIN;
          8'd2: sh_urp_q  <= bram.BRAM_DIN;
          8'd3: sh_csi_q  <= bram.BRAM_DIN;
          8'd4: begin
            mode_q    <= sh_mode_q;
            uri_q     <= sh_uri_q;
            urp_q     <= sh_urp_q;
            csi_q     <= sh_csi_q;
            csp_q     <= bram.BRAM_DIN;
            sil_upd_q <= 1'b1;
          end
          default: ;
        endcase
      end
`ifdef DEBUG_SETTINGS_EN
      if (state_q == RD_DBG && cnt_q >= LAT) begin
        if (cap_idx == 8'd7) begin
          for (int unsigned i = 0; i < 4; i++) dbg_type_q[i] <= sh_type_q[i];
          for (int unsigned i = 0; i < 3; i++) dbg_val_q[i] <= sh_val_q[i];
          dbg_val_q[3] <= bram.BRAM_DIN;
          dbg_upd_q    <= 1'b1;
        end else if (!cap_idx[0]) begin
          sh_type_q[cap_idx[2:1]] <= bram.BRAM_DIN[7:0];
        end else begin
          sh_val_q[cap_idx[2:1]] <= bram.BRAM_DIN;
        end
      end
`endif
    end
  end

  assign FORCE_FAN                  = force_fan_q;
  assign SILENCER_MODE              = mode_q;
  assign UPDATE_RATE_INTENSITY      = uri_q;
  assign UPDATE_RATE_PHASE          = urp_q;
  assign COMPLETION_STEPS_INTENSITY = csi_q;
  assign COMPLETION_STEPS_PHASE     = csp_q;
  assign SILENCER_UPDATE            = sil_upd_q;
`ifdef DEBUG_SETTINGS_EN
  assign DEBUG_TYPE   = dbg_type_q;
  assign DEBUG_VALUE  = dbg_val_q;
  assign DEBUG_UPDATE = dbg_upd_q;
`endif

endmodule

// File: tb/tb_ctl_reg_reader.sv
module tb_ctl_reg_reader;
  localparam int L = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        THERMO = 1'b0;
  logic        FORCE_FAN, SILENCER_MODE, SILENCER_UPDATE;
  logic [15:0] URI, URP, CSI, CSP;
`ifdef DEBUG_SETTINGS_EN
  logic [7:0]  DEBUG_TYPE  [0:3];
  logic [15:0] DEBUG_VALUE [0:3];
  logic        DEBUG_UPDATE;
`endif

  ctl_reg_reader_if bif ();

  ctl_reg_reader #(.RD_LATENCY(L)) dut (
    .CLK                        (CLK),
    .RST                        (RST),
    .bram                       (bif),
    .THERMO                     (THERMO),
    .FORCE_FAN                  (FORCE_FAN),
    .SILENCER_MODE              (SILENCER_MODE),
    .UPDATE_RATE_INTENSITY      (URI),
    .UPDATE_RATE_PHASE          (URP),
    .COMPLETION_STEPS_INTENSITY (CSI),
    .COMPLETION_STEPS_PHASE     (CSP),
    .SILENCER_UPDATE            (SILENCER_UPDATE)
`ifdef DEBUG_SETTINGS_EN
    ,
    .DEBUG_TYPE                 (DEBUG_TYPE),
    .DEBUG_VALUE                (DEBUG_VALUE),
    .DEBUG_UPDATE               (DEBUG_UPDATE)
`endif
  );

  always #5 CLK = ~CLK;

  // BRAM model: data for the address of cycle t is on BRAM_DIN during t+L
  logic [15:0] mem [0:255];
  logic [7:0]  apipe [0:L-1];
  always @(posedge CLK) begin
    if (bif.BRAM_WE) mem[bif.BRAM_ADDR] <= bif.BRAM_DOUT;
    apipe[0] <= bif.BRAM_ADDR;
    for (int i = 1; i < L; i++) apipe[i] <= apipe[i-1];
  end
  assign bif.BRAM_DIN = mem[apipe[L-1]];

  // bus monitor
  int cyc = 0, sil_cnt = 0, sil_cyc = 0, we_bad = 0, dout_bad = 0;
  int wr1_cyc = 0, period = 0;
  logic [15:0] wr1_data = '0;
  always @(negedge CLK) begin
    cyc++;
    if (SILENCER_UPDATE) begin sil_cnt++; sil_cyc = cyc; end
    if (bif.BRAM_WE && !(bif.BRAM_ADDR inside {8'h01, 8'h02, 8'h03})) we_bad++;
    if (!bif.BRAM_WE && bif.BRAM_DOUT !== 16'h0) dout_bad++;
    if (bif.BRAM_WE && bif.BRAM_ADDR == 8'h01) begin
      period   = cyc - wr1_cyc;
      wr1_cyc  = cyc;
      wr1_data = bif.BRAM_DOUT;
    end
  end

  int n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int found, early, exp_sil, saved;
`ifdef DEBUG_SETTINGS_EN
  int dbg_cyc;
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < L; i++) apipe[i] = '0;

    // reset state
    steps(3);
    chk("rst_we", bif.BRAM_WE, 0);
    chk("rst_fan", FORCE_FAN, 0);
    chk("rst_upd", SILENCER_UPDATE, 0);
    chk("rst_uri", URI, 0);

    // version writes then control read
    RST = 1'b0;
    #1;
    chk("ver_maj_addr", bif.BRAM_ADDR, 8'h02);
    chk("ver_maj_data", bif.BRAM_DOUT, 16'h0090);
    chk("ver_maj_we", bif.BRAM_WE, 1);
    step();
    chk("ver_min_addr", bif.BRAM_ADDR, 8'h03);
    chk("ver_min_data", bif.BRAM_DOUT, 16'h0000);
    chk("ver_min_we", bif.BRAM_WE, 1);
    step();
    chk("rdctl_addr", bif.BRAM_ADDR, 8'h00);
    chk("rdctl_we", bif.BRAM_WE, 0);

    // idle polling
    steps(15);
    chk("mem_ver_maj", mem[2], 16'h0090);
    chk("idle_period", period, 5);
    chk("idle_thermo", wr1_data, 16'h0000);
    chk("idle_no_upd", sil_cnt, 0);

    // silencer reload
    mem[8'h40] = 16'h0001; mem[8'h41] = 16'h0100; mem[8'h42] = 16'h0200;
    mem[8'h43] = 16'd10;   mem[8'h44] = 16'd40;
    mem[0] = 16'h0004;
    found = 0; early = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      step();
      if (SILENCER_UPDATE) found = 1;
      else if (URI != 16'h0 || SILENCER_MODE) early++;
    end
    chk("sil_pulse_seen", found, 1);
    chk("sil_not_early", early, 0);
    chk("sil_mode", SILENCER_MODE, 1);
    chk("sil_uri", URI, 16'h0100);
    chk("sil_urp", URP, 16'h0200);
    chk("sil_csi", CSI, 16'd10);
    chk("sil_csp", CSP, 16'd40);
    step();
    chk("sil_pulse_width", SILENCER_UPDATE, 0);
    steps(40);
    chk("sil_held_no_retrig", sil_cnt, 1);

    // clear and set again re-triggers
    mem[0] = 16'h0000;
    steps(15);
    mem[0] = 16'h0004;
    steps(30);
    chk("sil_toggle_count", sil_cnt, 2);
    exp_sil = 2;

    // thermal report and fan force
    THERMO = 1'b1;
    mem[0] = 16'h2004;
    steps(14);
    chk("thermo_write", wr1_data, 16'h0001);
    chk("force_fan", FORCE_FAN, 1);
    chk("fan_period", period, 5);
    chk("fan_no_retrig", sil_cnt, exp_sil);

    mem[0] = 16'h2000;
    steps(15);
`ifdef DEBUG_SETTINGS_EN
    mem[8'hF0] = 16'h0001; mem[8'hF1] = 16'd5; mem[8'hF2] = 16'h0002; mem[8'hF3] = 16'd6;
    mem[8'hF4] = 16'h0010; mem[8'hF5] = 16'd7; mem[8'hF6] = 16'h00E0; mem[8'hF7] = 16'd8;
    mem[0] = 16'h2014;
    found = 0; dbg_cyc = 0;
    for (int i = 0; i < 80 && found == 0; i++) begin
      step();
      if (DEBUG_UPDATE) begin found = 1; dbg_cyc = cyc; end
    end
    exp_sil++;
    chk("dbg_pulse_seen", found, 1);
    chk("sil_before_dbg", (sil_cyc < dbg_cyc) ? 1 : 0, 1);
    chk("dbg_sil_count", sil_cnt, exp_sil);
    chk("dbg_type0", DEBUG_TYPE[0], 8'h01);
    chk("dbg_type1", DEBUG_TYPE[1], 8'h02);
    chk("dbg_type2", DEBUG_TYPE[2], 8'h10);
    chk("dbg_type3", DEBUG_TYPE[3], 8'hE0);
    chk("dbg_val0", DEBUG_VALUE[0], 16'd5);
    chk("dbg_val1", DEBUG_VALUE[1], 16'd6);
    chk("dbg_val2", DEBUG_VALUE[2], 16'd7);
    chk("dbg_val3", DEBUG_VALUE[3], 16'd8);
`else
    // bit 4 alone must not lengthen the poll
    mem[0] = 16'h2010;
    steps(20);
    chk("bit4_ignored_period", period, 5);
    chk("bit4_ignored_sil", sil_cnt, exp_sil);
`endif

    // reset during the third silencer word
    mem[0] = 16'h0000;
    steps(15);
    mem[0] = 16'h0004;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step();
      if (bif.BRAM_ADDR == 8'h42) found = 1;
    end
    chk("burst_word3_seen", found, 1);
    saved = sil_cnt;
    RST = 1'b1;
    step();
    chk("midrst_mode", SILENCER_MODE, 0);
    chk("midrst_uri", URI, 0);
    chk("midrst_csp", CSP, 0);
    chk("midrst_fan", FORCE_FAN, 0);
    RST = 1'b0;
    #1;
    chk("midrst_ver_maj", bif.BRAM_ADDR, 8'h02);
    chk("midrst_ver_we", bif.BRAM_WE, 1);
    step();
    chk("midrst_ver_min", bif.BRAM_ADDR, 8'h03);
    chk("midrst_no_pulse", sil_cnt, saved);
    steps(30);
    chk("midrst_reload", sil_cnt, saved + 1);
    chk("midrst_reload_csp", CSP, 16'd40);

    chk("we_only_on_writes", we_bad, 0);
    chk("dout_zero_when_idle", dout_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
